// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the universal-gate sweep checker: select encodings,
// FSM state type and the golden gate function used by RTL and bench alike.
package gate_sweep_checker_pkg;

    localparam logic [2:0] SEL_NOT   = 3'd0;
    localparam logic [2:0] SEL_NOR   = 3'd1;
    localparam logic [2:0] SEL_AND   = 3'd2;
    localparam logic [2:0] SEL_OR    = 3'd3;
    localparam logic [2:0] SEL_XOR   = 3'd4;
    localparam logic [2:0] SEL_XNOR  = 3'd5;
    localparam logic [2:0] SEL_NAND  = 3'd6;
    localparam logic [2:0] SEL_NAND2 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic gate_golden(input logic [2:0] sel, input logic a, input logic b);
        logic r;
        case (sel)
            SEL_NOT:   r = ~a;
            SEL_NOR:   r = ~(a | b);
            SEL_AND:   r = a & b;
            SEL_OR:    r = a | b;
            SEL_XOR:   r = a ^ b;
            SEL_XNOR:  r = ~(a ^ b);
            SEL_NAND:  r = ~(a & b);
            SEL_NAND2: r = ~(a & b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_gate_golden_model.sv
// Combinational reference gate: wraps the package golden function so the
// expected value comes from the same definition everywhere.
module gate_golden_model
    import gate_sweep_checker_pkg::*;
(
    input  logic [2:0] sel_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic       exp_o
);

    assign exp_o = gate_golden(sel_i, a_i, b_i);

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all 32 {sel,a,b} vectors into a universal-gate block, samples its
// output after SETTLE idle cycles and accumulates per-function results.
module gate_sweep_checker
    import gate_sweep_checker_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] pass_map,
    output logic [5:0] fail_count,
    output logic       first_fail_valid,
    output logic [4:0] first_fail_vec
);

    localparam bit         HAS_WAIT  = (SETTLE > 0);
    localparam logic [3:0] SETTLE_M1 = HAS_WAIT ? 4'(SETTLE - 1) : 4'd0;

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] pass_q, pass_d;
    logic [5:0] fail_q, fail_d;
    logic       ffv_q, ffv_d;
    logic [4:0] ffvec_q, ffvec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       exp_s;
    logic       mismatch_s;

    gate_golden_model u_golden (
        .sel_i (idx_q[4:2]),
        .a_i   (idx_q[1]),
        .b_i   (idx_q[0]),
        .exp_o (exp_s)
    );

    assign mismatch_s = (dut_out != exp_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_DRIVE;
                else       state_d = ST_IDLE;
            end
            ST_DRIVE: begin
                if (HAS_WAIT) state_d = ST_WAIT;
                else          state_d = ST_SAMPLE;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = ST_SAMPLE;
                else                    state_d = ST_WAIT;
            end
            ST_SAMPLE: begin
                if (idx_q == 5'd31) state_d = ST_DONE;
                else                state_d = ST_DRIVE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they align with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_DRIVE, ST_WAIT, ST_SAMPLE: busy_d = 1'b1;
            ST_DONE:                      done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Vector index, settle counter and result accumulation.
    always_comb begin
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = 5'd0;
                    pass_d  = 8'hFF;
                    fail_d  = 6'd0;
                    ffv_d   = 1'b0;
                    ffvec_d = 5'd0;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DRIVE: wait_cnt_d = SETTLE_M1;
            ST_WAIT: begin
                if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
                else                    wait_cnt_d = 4'd0;
            end
            ST_SAMPLE: begin
                if (mismatch_s) begin
                    pass_d[idx_q[4:2]] = 1'b0;
                    fail_d             = fail_q + 6'd1;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = idx_q;
                    end else begin
                        ffvec_d = ffvec_q;
                    end
                end else begin
                    fail_d = fail_q;
                end
                // The last vector stays on a/b/sel after the run.
                if (idx_q != 5'd31) idx_d = idx_q + 5'd1;
                else                idx_d = idx_q;
            end
            ST_DONE: idx_d = idx_q;
            default: idx_d = idx_q;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= 5'd0;
            wait_cnt_q <= 4'd0;
            pass_q     <= 8'h00;
            fail_q     <= 6'd0;
            ffv_q      <= 1'b0;
            ffvec_q    <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ffv_q      <= ffv_d;
            ffvec_q    <= ffvec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sel              = idx_q[4:2];
    assign a                = idx_q[1];
    assign b                = idx_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass_map         = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: a table of full sweeps against several gate-block behaviours
// on SETTLE=1 and SETTLE=0 instances, plus held-start and mid-run reset cases.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       dout0, dout1;
    logic       a0, b0, a1, b1;
    logic [2:0] sel0, sel1;
    logic       busy0, busy1, done0, done1;
    logic [7:0] pm0, pm1;
    logic [5:0] fc0, fc1;
    logic       ffv0, ffv1;
    logic [4:0] ffvec0, ffvec1;

    int errors = 0;
    int checks = 0;
    int mode   = 0;

    always #5 clk = ~clk;

    gate_sweep_checker #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_out(dout1),
        .a(a1), .b(b1), .sel(sel1), .busy(busy1), .done(done1),
        .pass_map(pm1), .fail_count(fc1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    gate_sweep_checker #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_out(dout0),
        .a(a0), .b(b0), .sel(sel0), .busy(busy0), .done(done0),
        .pass_map(pm0), .fail_count(fc0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
    );

    // Truth table per select, bit index {a,b}.
    function automatic logic ref_gate(input logic [2:0] s, input logic x, input logic y);
        logic [3:0] t;
        logic [1:0] k;
        case (s)
            3'd0:    t = 4'b0011;
            3'd1:    t = 4'b0001;
            3'd2:    t = 4'b1000;
            3'd3:    t = 4'b1110;
            3'd4:    t = 4'b0110;
            3'd5:    t = 4'b1001;
            3'd6:    t = 4'b0111;
            3'd7:    t = 4'b0111;
            default: t = 4'b0000;
        endcase
        k = {x, y};
        return t[k];
    endfunction

    // Behaviours: 0 good, 1 sel7 computes AND, 2 stuck 0, 3 stuck 1, 4 inverted.
    function automatic logic gate_block(input int m, input logic [2:0] s, input logic x, input logic y);
        case (m)
            1:       return (s == 3'd7) ? (x & y) : ref_gate(s, x, y);
            2:       return 1'b0;
            3:       return 1'b1;
            4:       return ~ref_gate(s, x, y);
            default: return ref_gate(s, x, y);
        endcase
    endfunction

    assign dout0 = gate_block(mode, sel0, a0, b0);
    assign dout1 = gate_block(mode, sel1, a1, b1);

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done0 : done1;
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy0 : busy1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " a/b/sel"}, {29'd0, sel1, a1, b1}, 32'd0);
        check({tag, " busy"}, {31'd0, busy1}, 32'd0);
        check({tag, " done"}, {31'd0, done1}, 32'd0);
        check({tag, " pass_map"}, {24'd0, pm1}, 32'd0);
        check({tag, " fail_count"}, {26'd0, fc1}, 32'd0);
        check({tag, " ffv"}, {31'd0, ffv1}, 32'd0);
        check({tag, " ffvec"}, {27'd0, ffvec1}, 32'd0);
    endtask

    // Pulse start in cycle 0 and return the cycle in which done is seen (-1 on timeout).
    task automatic do_run(input int inst, output int done_cyc, output int busy_gaps);
        @(negedge clk);
        if (inst == 0) start0 = 1'b1;
        else           start1 = 1'b1;
        done_cyc  = -1;
        busy_gaps = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
            @(negedge clk);
            if (get_done(inst)) begin
                done_cyc = c;
                break;
            end
            if (!get_busy(inst)) busy_gaps++;
        end
    endtask

    typedef struct {
        int         inst;
        int         mode;
        int         exp_done;
        logic [7:0] exp_pass;
        logic [5:0] exp_fail;
        logic       exp_ffv;
        logic [4:0] exp_ffvec;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int dc, gaps, npulse, c;
        int dcyc[$];
        string tag;

        tbl[0] = '{1, 0, 97, 8'hFF, 6'd0,  1'b0, 5'd0};
        tbl[1] = '{1, 1, 97, 8'h7F, 6'd4,  1'b1, 5'd28};
        tbl[2] = '{1, 2, 97, 8'h00, 6'd17, 1'b1, 5'd0};
        tbl[3] = '{1, 3, 97, 8'h00, 6'd15, 1'b1, 5'd2};
        tbl[4] = '{1, 4, 97, 8'h00, 6'd32, 1'b1, 5'd0};
        tbl[5] = '{0, 0, 65, 8'hFF, 6'd0,  1'b0, 5'd0};
        tbl[6] = '{0, 2, 65, 8'h00, 6'd17, 1'b1, 5'd0};

        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            mode = tbl[i].mode;
            tag  = $sformatf("run%0d", i);
            do_run(tbl[i].inst, dc, gaps);
            check({tag, " done cycle"}, dc, tbl[i].exp_done);
            check({tag, " busy gaps"}, gaps, 0);
            if (tbl[i].inst == 0) begin
                check({tag, " pass_map"}, {24'd0, pm0}, {24'd0, tbl[i].exp_pass});
                check({tag, " fail_count"}, {26'd0, fc0}, {26'd0, tbl[i].exp_fail});
                check({tag, " ffv"}, {31'd0, ffv0}, {31'd0, tbl[i].exp_ffv});
                check({tag, " ffvec"}, {27'd0, ffvec0}, {27'd0, tbl[i].exp_ffvec});
                check({tag, " last vector"}, {29'd0, sel0, a0, b0}, 32'd31);
            end else begin
                check({tag, " pass_map"}, {24'd0, pm1}, {24'd0, tbl[i].exp_pass});
                check({tag, " fail_count"}, {26'd0, fc1}, {26'd0, tbl[i].exp_fail});
                check({tag, " ffv"}, {31'd0, ffv1}, {31'd0, tbl[i].exp_ffv});
                check({tag, " ffvec"}, {27'd0, ffvec1}, {27'd0, tbl[i].exp_ffvec});
                check({tag, " last vector"}, {29'd0, sel1, a1, b1}, 32'd31);
            end
            @(negedge clk);
            check({tag, " done one cycle"}, {31'd0, get_done(tbl[i].inst)}, 32'd0);
            check({tag, " idle not busy"}, {31'd0, get_busy(tbl[i].inst)}, 32'd0);
            check({tag, " results held"}, {24'd0, (tbl[i].inst == 0) ? pm0 : pm1},
                  {24'd0, tbl[i].exp_pass});
        end

        // start held high for 250 cycles: back-to-back runs.
        mode = 0;
        @(negedge clk);
        start1 = 1'b1;
        gaps   = 0;
        for (int k = 1; k <= 250; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) dcyc.push_back(k);
            if (!busy1) gaps++;
        end
        start1 = 1'b0;
        check("held done pulses", dcyc.size(), 2);
        if (dcyc.size() >= 2) begin
            check("held first done", dcyc[0], 97);
            check("held second done", dcyc[1], 195);
        end
        check("held busy low cycles", gaps, 4);
        c = 0;
        while (!done1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("held third run ends", {31'd0, done1}, 32'd1);
        @(negedge clk);

        // Reset in cycle 40 of a failing run.
        mode = 2;
        @(negedge clk);
        start1 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            @(negedge clk);
        end
        check("pre-reset fail_count nonzero", {31'd0, (fc1 != 6'd0)}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrun rst");
        rst    = 1'b0;
        npulse = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (done1) npulse++;
        end
        check("no done after rst", npulse, 0);
        check("idle after rst busy", {31'd0, busy1}, 32'd0);
        mode = 0;
        do_run(1, dc, gaps);
        check("post-rst done cycle", dc, 97);
        check("post-rst pass_map", {24'd0, pm1}, 32'hFF);
        check("post-rst fail_count", {26'd0, fc1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
